div_feeder: RTL and testbench

Front-end sequencer for the Q16.16 Newton-Raphson divider core. It buffers numerator/denominator pairs in a small FIFO and converts signed operands to magnitudes. It issues one division at a time over the core's in_valid/ready handshake, then captures the result and restores its sign. After each result it pulses the core's reset, because the core holds its result with out_valid high until it is reset. Results leave on a valid/ready stream.

---
 rtl/div_feeder.sv | 140 ++++++++++++++
 tb/tb_div_feeder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_feeder.sv
// Sequencer in front of the Q16.16 Newton-Raphson divider core: FIFO, sign handling, one-op-at-a-time issue.
// Optional divide-by-zero bypass enabled by defining DIV_FEEDER_DBZ_EN.
module div_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_num,
  input  logic [WIDTH-1:0] s_den,
  output logic [WIDTH-1:0] div_n,
  output logic [WIDTH-1:0] div_d,
  output logic             div_in_valid,
  input  logic             div_ready,
  input  logic             div_out_valid,
  input  logic [WIDTH-1:0] div_out,
  output logic             div_rst,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quot,
  output logic             m_dbz
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, OUT} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] fifo_num [DEPTH];
  logic [WIDTH-1:0] fifo_den [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head_num, head_den;
  logic             dbz_head;
  logic             neg;

  // Most negative value has no positive twin; saturate it.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (x == MIN_NEG) return MAX_POS;
    else if (x[WIDTH-1]) return -x;
    else return x;
  endfunction

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign s_ready  = !full;
  assign push     = s_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign head_num = fifo_num[rd_ptr];
  assign head_den = fifo_den[rd_ptr];

`ifdef DIV_FEEDER_DBZ_EN
  assign dbz_head = (head_den == '0);
`else
  assign dbz_head = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_num[wr_ptr] <= s_num;
      fifo_den[wr_ptr] <= s_den;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = dbz_head ? OUT : ISSUE;
      ISSUE:   if (div_ready) state_nx = WAIT;
      WAIT:    if (div_out_valid) state_nx = RELEASE;
      RELEASE: state_nx = OUT;
      OUT:     if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign div_in_valid = (state == ISSUE);
  assign m_valid      = (state == OUT);
  assign div_rst      = rst | (state == RELEASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_n  <= '0;
      div_d  <= '0;
      neg    <= 1'b0;
      m_quot <= '0;
    end else begin
      if (pop) begin
        if (dbz_head) begin
          m_quot <= head_num[WIDTH-1] ? MIN_NEG : MAX_POS;
        end else begin
          div_n <= mag(head_num);
          div_d <= mag(head_den);
          neg   <= head_num[WIDTH-1] ^ head_den[WIDTH-1];
        end
      end
      if (state == WAIT && div_out_valid)
        m_quot <= neg ? -div_out : div_out;
    end
  end

`ifdef DIV_FEEDER_DBZ_EN
  logic dbz_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbz_q <= 1'b0;
    else if (pop) dbz_q <= dbz_head;
  end
  assign m_dbz = dbz_q;
`else
  assign m_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_feeder.sv
// Self-checking bench for div_feeder with a behavioural divider-core model and a result scoreboard.
module tb_div_feeder;
  localparam int W = 32;
  localparam int D = 4;

`ifdef DIV_FEEDER_DBZ_EN
  localparam bit DBZ_ON = 1'b1;
`else
  localparam bit DBZ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_num = '0;
  logic [W-1:0] s_den = '0;
  logic [W-1:0] div_n, div_d;
  logic         div_in_valid;
  logic         div_ready;
  logic         div_out_valid = 1'b0;
  logic [W-1:0] div_out = '0;
  logic         div_rst;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_quot;
  logic         m_dbz;

  div_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_num(s_num), .s_den(s_den),
    .div_n(div_n), .div_d(div_d), .div_in_valid(div_in_valid), .div_ready(div_ready),
    .div_out_valid(div_out_valid), .div_out(div_out), .div_rst(div_rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_quot(m_quot), .m_dbz(m_dbz)
  );

  always #5 clk = ~clk;

  // Divider core model: accepts when idle, answers after core_lat cycles, holds until reset.
  logic         core_busy = 1'b0;
  logic         core_hold = 1'b0;
  int unsigned  core_cnt = 0;
  int unsigned  core_lat = 3;
  logic [W-1:0] core_res = '0;

  assign div_ready = !core_busy && !core_hold;

  function automatic logic [W-1:0] core_div(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [63:0] q;
    if (d == '0) return '1;
    q = {16'd0, n, 16'd0} / {32'd0, d};
    return q[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (div_rst) begin
      core_busy     <= 1'b0;
      core_hold     <= 1'b0;
      div_out_valid <= 1'b0;
      div_out       <= '0;
    end else if (div_in_valid && div_ready) begin
      core_busy <= 1'b1;
      core_cnt  <= core_lat;
      core_res  <= core_div(div_n, div_d);
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy     <= 1'b0;
        core_hold     <= 1'b1;
        div_out_valid <= 1'b1;
        div_out       <= core_res;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Reference model of what the feeder must produce.
  typedef struct { logic [W-1:0] q; logic dbz; } res_t;
  typedef struct { logic [W-1:0] n; logic [W-1:0] d; } iss_t;
  res_t exp_q[$];
  iss_t iss_q[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int issue_cnt = 0;
  logic         prev_mv = 1'b0, prev_mr = 1'b0, prev_dbz = 1'b0;
  logic [W-1:0] prev_q = '0;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    return x[W-1] ? (32'd0 - x) : x;
  endfunction

  function automatic logic [W-1:0] model_quot(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [63:0] full_q;
    logic [W-1:0] q;
    full_q = ({32'd0, mag(n)} << 16) / {32'd0, mag(d)};
    q = full_q[W-1:0];
    return (n[W-1] ^ d[W-1]) ? (32'd0 - q) : q;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    int diff;
    total++;
    diff = int'(act - exp);
    if (diff > 4 || diff < -4) begin
      bad++;
      $display("FAIL %s: got %h expected %h +-4 at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    res_t r;
    iss_t e;
    if (rst) begin
      exp_q.delete();
      iss_q.delete();
      pulses  = 0;
      prev_mv = 1'b0;
      prev_mr = 1'b0;
      return;
    end
    if (div_rst) pulses++;
    if (div_in_valid && div_ready) begin
      issue_cnt++;
      if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        e = iss_q.pop_front();
        chk("div_n", div_n, e.n);
        chk("div_d", div_d, e.d);
      end
    end
    if (m_valid) chk("issue_while_out", div_in_valid, 0);
    if (m_valid && prev_mv && !prev_mr) begin
      chk("quot_stable", m_quot, prev_q);
      chk("dbz_stable", m_dbz, prev_dbz);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        r = exp_q.pop_front();
        chk("m_quot", m_quot, r.q);
        chk("m_dbz", m_dbz, r.dbz);
        chk("rst_pulses", pulses, r.dbz ? 0 : 1);
      end
      pulses = 0;
    end
    if (s_valid && s_ready) begin
      if (DBZ_ON && s_den == '0) begin
        exp_q.push_back('{s_num[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1});
      end else begin
        exp_q.push_back('{model_quot(s_num, s_den), 1'b0});
        iss_q.push_back('{mag(s_num), mag(s_den)});
      end
    end
    prev_mv  = m_valid;
    prev_mr  = m_ready;
    prev_q   = m_quot;
    prev_dbz = m_dbz;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] n, input logic [W-1:0] d);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_num = n;
    s_den = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = s_ready;
      step();
    end
    s_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_mvalid();
    for (int i = 0; i < 300 && !m_valid; i++) step();
    if (!m_valid) chk("mvalid_timeout", 0, 1);
  endtask

  task automatic take();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic run_one(input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] q, input logic dbz);
    push_pair(n, d);
    wait_mvalid();
    chk_near("lit_quot", m_quot, q);
    chk("lit_dbz", m_dbz, dbz);
    take();
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || m_valid); i++) step();
    m_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  logic [W-1:0] p_num [5] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0012_3456, 32'h8000_0000, 32'h7FFF_0000};
  logic [W-1:0] p_den [5] = '{32'h0003_0000, 32'h0002_0000, 32'hFFFC_0000, 32'h0001_0000, 32'h0000_8000};

  initial begin
    int acc;
    int issues_before;
    rst = 1'b1;
    step();
    step();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_quot", m_quot, 0);
    chk("rst_m_dbz", m_dbz, 0);
    chk("rst_div_n", div_n, 0);
    chk("rst_div_d", div_d, 0);
    chk("rst_in_valid", div_in_valid, 0);
    chk("rst_div_rst", div_rst, 1);
    rst = 1'b0;
    step();

    // Issue and return latency with a literal result.
    s_valid = 1'b1; s_num = 32'h0006_0000; s_den = 32'h0002_0000;
    step();
    s_valid = 1'b0;
    chk("lat_k_in_valid", div_in_valid, 0);
    step();
    chk("lat_k1_in_valid", div_in_valid, 1);
    chk("lat_k1_div_n", div_n, 32'h0006_0000);
    step();
    chk("lat_k2_in_valid", div_in_valid, 0);
    for (int i = 0; i < 50 && !div_out_valid; i++) step();
    chk("core_answered", div_out_valid, 1);
    chk("lat_j_div_rst", div_rst, 0);
    step();
    chk("lat_j1_div_rst", div_rst, 1);
    chk("lat_j1_m_valid", m_valid, 0);
    step();
    chk("lat_j2_m_valid", m_valid, 1);
    chk("lat_j2_div_rst", div_rst, 0);
    chk_near("lit_6_2", m_quot, 32'h0003_0000);
    chk("lit_6_2_dbz", m_dbz, 0);
    for (int i = 0; i < 10; i++) step();
    chk_near("hold_quot", m_quot, 32'h0003_0000);
    chk("hold_m_valid", m_valid, 1);
    take();
    chk("idle_after_take", m_valid, 0);

    run_one(32'hFFFA_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b0);
    run_one(32'hFFFA_0000, 32'hFFFE_0000, 32'h0003_0000, 1'b0);

    // Back-pressure: hold one result, then fill the FIFO.
    push_pair(32'h0001_0000, 32'h0001_0000);
    wait_mvalid();
    acc = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      s_num = p_num[acc]; s_den = p_den[acc];
      if (s_ready) acc++;
      step();
    end
    s_num = p_num[4]; s_den = p_den[4];
    chk("full_accepts", acc, 4);
    for (int i = 0; i < 3; i++) begin
      chk("full_s_ready", s_ready, 0);
      step();
    end
    take();
    for (int i = 0; i < 10 && acc < 5; i++) begin
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    chk("fifth_accepted", acc, 5);
    drain();

`ifdef DIV_FEEDER_DBZ_EN
    issues_before = issue_cnt;
    run_one(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
    run_one(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
    chk("dbz_no_issue", issue_cnt, issues_before);
`endif

    // Reset while waiting on the core with entries queued.
    core_lat = 30;
    push_pair(32'h0004_0000, 32'h0002_0000);
    push_pair(32'h0009_0000, 32'h0003_0000);
    push_pair(32'h000A_0000, 32'h0005_0000);
    step();
    chk("in_wait_in_valid", div_in_valid, 0);
    chk("in_wait_out_valid", div_out_valid, 0);
    rst = 1'b1;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_s_ready", s_ready, 1);
    chk("async_div_rst", div_rst, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_hold_s_ready", s_ready, 1);
      chk("rst_hold_m_valid", m_valid, 0);
    end
    rst = 1'b0;
    core_lat = 2;
    issue_cnt = 0;
    for (int i = 0; i < 10; i++) step();
    chk("no_issue_after_rst", issue_cnt, 0);
    run_one(32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_num = $urandom;
      case ($urandom_range(0, 7))
        0:       s_den = 32'h8000_0000;
        1:       s_den = DBZ_ON ? 32'd0 : 32'd1;
        2:       s_den = $urandom >> $urandom_range(8, 28);
        default: s_den = $urandom >> $urandom_range(0, 12);
      endcase
      if (!DBZ_ON && s_den == '0) s_den = 32'h0001_0000;
      m_ready = ($urandom_range(0, 3) != 0);
      core_lat = $urandom_range(0, 6);
      step();
    end
    s_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
